// File: rtl/inst_rom_pkg.sv
// Shared types and defaults for the banked instruction ROM.
// Parity storage is enabled by defining INST_ROM_PARITY_EN.
package inst_rom_pkg;

   localparam int unsigned IW_DEF    = 16;
   localparam int unsigned DW_DEF    = 9;
   localparam int unsigned NBANK_DEF = 4;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      RUN
   } rom_state_t;

   // Even parity over a zero-extended word: 1 when the word has an odd number of ones.
   function automatic logic even_parity(input logic [63:0] w);
      return ^w;
   endfunction

endpackage

// File: rtl/rom_bank.sv
// One program image: DEPTH x W array, single write port, registered read port.
// The read register holds its value whenever no read is issued.
module rom_bank #(
   parameter int unsigned AW    = 16,
   parameter int unsigned DEPTH = 2**AW,
   parameter int unsigned W     = 9
)(
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [DEPTH];

   // Contents are intentionally not reset so images survive a reset.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/inst_rom_banked.sv
// Banked instruction memory: serial image loader, IDLE/LOAD/RUN sequencer and fetch port.
// Define INST_ROM_PARITY_EN to store a parity bit per word and expose ParErr.
module inst_rom_banked
   import inst_rom_pkg::*;
#(
   parameter int unsigned IW    = IW_DEF,
   parameter int unsigned DW    = DW_DEF,
   parameter int unsigned DEPTH = 2**IW,
   parameter int unsigned NBANK = NBANK_DEF,
   localparam int unsigned BW   = $clog2(NBANK)
)(
   input  logic          Clk,
   input  logic          Reset_n,
   input  logic [BW-1:0] ProgSel,
   input  logic          Start,
   input  logic          Halt,
   input  logic          LoadStart,
   input  logic          LoadValid,
   input  logic [DW-1:0] LoadData,
   input  logic          LoadDone,
   input  logic [IW-1:0] InstAddress,
   input  logic          FetchReq,
   input  logic          Stall,
   output logic [DW-1:0] InstOut,
   output logic          InstValid,
   output logic          AddrErr,
   output logic [BW-1:0] ActiveBank,
   output logic          Busy,
`ifdef INST_ROM_PARITY_EN
   output logic          ParErr,
`endif
   output logic [IW:0]   LoadCount
);

`ifdef INST_ROM_PARITY_EN
   localparam int unsigned SW = DW + 1;
`else
   localparam int unsigned SW = DW;
`endif
   localparam int unsigned CW = IW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   rom_state_t    state_q, state_d;
   logic [BW-1:0] load_bank_q;
   logic [BW-1:0] rd_bank_q;
   logic [CW-1:0] load_cnt_q;
   logic          valid_q;
   logic          err_q;
   logic          has_word_q;

   logic          load_begin_c;
   logic          run_begin_c;
   logic          write_c;
   logic          accept_c;
   logic          in_range_c;
   logic [SW-1:0] wdata_c;
   logic [SW-1:0] sel_word_c;
   logic          word_live_c;
   logic [SW-1:0] bank_rdata [NBANK];

   assign in_range_c = CW'(InstAddress) < DEPTH_C;

   // Next-state and per-cycle strobes.
   always_comb begin
      state_d      = state_q;
      load_begin_c = 1'b0;
      run_begin_c  = 1'b0;
      write_c      = 1'b0;
      accept_c     = 1'b0;
      case (state_q)
         IDLE: begin
            if (LoadStart) begin
               state_d      = LOAD;
               load_begin_c = 1'b1;
            end else if (Start) begin
               state_d     = RUN;
               run_begin_c = 1'b1;
            end
         end
         LOAD: begin
            write_c = LoadValid && (load_cnt_q < DEPTH_C);
            if (LoadDone) state_d = IDLE;
         end
         RUN: begin
            // A fetch issued in the Halt cycle is discarded.
            accept_c = FetchReq && !Stall && !Halt;
            if (Halt) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q     <= IDLE;
         load_bank_q <= '0;
         load_cnt_q  <= '0;
         ActiveBank  <= '0;
         rd_bank_q   <= '0;
         valid_q     <= 1'b0;
         err_q       <= 1'b0;
         has_word_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (load_begin_c) begin
            load_bank_q <= ProgSel;
            load_cnt_q  <= '0;
         end else if (write_c) begin
            load_cnt_q <= load_cnt_q + CW'(1);
         end
         if (run_begin_c) ActiveBank <= ProgSel;
         if (state_q != RUN || Halt) valid_q <= 1'b0;
         else if (!Stall)            valid_q <= FetchReq;
         if (accept_c) begin
            err_q      <= !in_range_c;
            rd_bank_q  <= ActiveBank;
            has_word_q <= 1'b1;
         end
      end
   end

`ifdef INST_ROM_PARITY_EN
   assign wdata_c = {even_parity(64'(LoadData)), LoadData};
`else
   assign wdata_c = LoadData;
`endif

   for (genvar b = 0; b < NBANK; b++) begin : g_bank
      rom_bank #(
         .AW    (IW),
         .DEPTH (DEPTH),
         .W     (SW)
      ) u_bank (
         .clk   (Clk),
         .we    (write_c && (load_bank_q == BW'(b))),
         .waddr (load_cnt_q[IW-1:0]),
         .wdata (wdata_c),
         .re    (accept_c && in_range_c && (ActiveBank == BW'(b))),
         .raddr (InstAddress),
         .rdata (bank_rdata[b])
      );
   end

   // Bank read registers act as the output register; out-of-range or pre-fetch shows zero.
   assign sel_word_c  = bank_rdata[rd_bank_q];
   assign word_live_c = has_word_q && !err_q;
   assign InstOut     = word_live_c ? sel_word_c[DW-1:0] : '0;
   assign InstValid   = valid_q;
   assign AddrErr     = err_q;
   assign Busy        = (state_q != IDLE);
   assign LoadCount   = load_cnt_q;
`ifdef INST_ROM_PARITY_EN
   assign ParErr      = word_live_c && even_parity(64'(sel_word_c));
`endif

endmodule

// File: tb/tb_inst_rom_banked.sv
// Self-checking bench for inst_rom_banked (small geometry: DEPTH=8 within a 4-bit address).
module tb_inst_rom_banked;

   localparam int unsigned IW    = 4;
   localparam int unsigned DW    = 9;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned NBANK = 4;
   localparam int unsigned BW    = 2;

   logic          Clk = 1'b0;
   logic          Reset_n = 1'b0;
   logic [BW-1:0] ProgSel = '0;
   logic          Start = 1'b0, Halt = 1'b0, LoadStart = 1'b0, LoadValid = 1'b0, LoadDone = 1'b0;
   logic [DW-1:0] LoadData = '0;
   logic [IW-1:0] InstAddress = '0;
   logic          FetchReq = 1'b0, Stall = 1'b0;
   logic [DW-1:0] InstOut;
   logic          InstValid, AddrErr, Busy;
   logic [BW-1:0] ActiveBank;
   logic [IW:0]   LoadCount;
`ifdef INST_ROM_PARITY_EN
   logic          par_err;
`endif

   int tests = 0;
   int fails = 0;

   always #5 Clk = ~Clk;

   inst_rom_banked #(.IW(IW), .DW(DW), .DEPTH(DEPTH), .NBANK(NBANK)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .ProgSel(ProgSel), .Start(Start), .Halt(Halt),
      .LoadStart(LoadStart), .LoadValid(LoadValid), .LoadData(LoadData), .LoadDone(LoadDone),
      .InstAddress(InstAddress), .FetchReq(FetchReq), .Stall(Stall),
      .InstOut(InstOut), .InstValid(InstValid), .AddrErr(AddrErr), .ActiveBank(ActiveBank),
      .Busy(Busy),
`ifdef INST_ROM_PARITY_EN
      .ParErr(par_err),
`endif
      .LoadCount(LoadCount)
   );

   // Reference model: mode 0=idle, 1=load, 2=run; memory images as plain arrays.
   int            m_mode = 0;
   logic [DW-1:0] m_mem [NBANK][DEPTH];
   int            m_out = 0, m_valid = 0, m_err = 0, m_bank = 0, m_lbank = 0, m_cnt = 0;

   initial begin
      for (int b = 0; b < NBANK; b++)
         for (int a = 0; a < DEPTH; a++) m_mem[b][a] = '0;
   end

   task automatic model_reset();
      m_mode = 0; m_out = 0; m_valid = 0; m_err = 0; m_bank = 0; m_lbank = 0; m_cnt = 0;
   endtask

   task automatic model_step();
      case (m_mode)
         0: begin
            m_valid = 0;
            if (LoadStart) begin m_mode = 1; m_lbank = int'(ProgSel); m_cnt = 0; end
            else if (Start) begin m_mode = 2; m_bank = int'(ProgSel); end
         end
         1: begin
            m_valid = 0;
            if (LoadValid && m_cnt < DEPTH) begin
               m_mem[m_lbank][m_cnt] = LoadData;
               m_cnt++;
            end
            if (LoadDone) m_mode = 0;
         end
         default: begin
            if (Halt) begin
               m_valid = 0; m_mode = 0;
            end else if (!Stall) begin
               if (FetchReq) begin
                  m_valid = 1;
                  if (int'(InstAddress) < DEPTH) begin
                     m_out = int'(m_mem[m_bank][int'(InstAddress)]); m_err = 0;
                  end else begin
                     m_out = 0; m_err = 1;
                  end
               end else m_valid = 0;
            end
         end
      endcase
   endtask

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_model(input string tag);
      chk({tag, " InstOut"},    int'(InstOut),    m_out);
      chk({tag, " InstValid"},  int'(InstValid),  m_valid);
      chk({tag, " AddrErr"},    int'(AddrErr),    m_err);
      chk({tag, " ActiveBank"}, int'(ActiveBank), m_bank);
      chk({tag, " Busy"},       int'(Busy),       (m_mode != 0) ? 1 : 0);
      chk({tag, " LoadCount"},  int'(LoadCount),  m_cnt);
`ifdef INST_ROM_PARITY_EN
      chk({tag, " ParErr"},     int'(par_err),    0);
`endif
   endtask

   task automatic clear_inputs();
      Start = 0; Halt = 0; LoadStart = 0; LoadValid = 0; LoadDone = 0; FetchReq = 0; Stall = 0;
   endtask

   // Called at a negedge with inputs already driven; advances one clock and checks at the next negedge.
   task automatic cycle(input string tag);
      @(posedge Clk);
      model_step();
      @(negedge Clk);
      check_model(tag);
   endtask

   task automatic do_reset(input string tag);
      Reset_n = 0;
      #1;
      model_reset();
      check_model(tag);
      @(posedge Clk);
      @(negedge Clk);
      Reset_n = 1;
   endtask

   task automatic fetch(input int addr, input string tag);
      clear_inputs(); FetchReq = 1; InstAddress = IW'(addr);
      cycle(tag);
   endtask

   typedef struct {
      logic [BW-1:0] prog;
      logic          start, halt, lstart, lvalid;
      logic [DW-1:0] ldata;
      logic          ldone;
      logic [IW-1:0] addr;
      logic          freq, stall;
      int            e_out, e_valid, e_err, e_bank, e_busy, e_cnt;
   } vec_t;

   function automatic vec_t mk(input int prog, input int st, input int hl, input int ls, input int lv,
                               input int ld, input int dn, input int ad, input int fr,
                               input int e_out, input int e_valid, input int e_err,
                               input int e_bank, input int e_busy, input int e_cnt);
      vec_t v;
      v.prog = BW'(prog); v.start = 1'(st); v.halt = 1'(hl); v.lstart = 1'(ls); v.lvalid = 1'(lv);
      v.ldata = DW'(ld); v.ldone = 1'(dn); v.addr = IW'(ad); v.freq = 1'(fr); v.stall = 1'b0;
      v.e_out = e_out; v.e_valid = e_valid; v.e_err = e_err;
      v.e_bank = e_bank; v.e_busy = e_busy; v.e_cnt = e_cnt;
      return v;
   endfunction

   vec_t tbl [10];

   initial begin
      //            prog st hl ls lv data   dn ad fr | out    v  e  bk by cnt
      tbl[0] = mk(1, 0, 0, 1, 0, 0,     0, 0, 0,   0,     0, 0, 0, 1, 0);
      tbl[1] = mk(0, 0, 0, 0, 1, 'h1A5, 0, 0, 0,   0,     0, 0, 0, 1, 1);
      tbl[2] = mk(0, 0, 0, 0, 1, 'h0F3, 0, 0, 0,   0,     0, 0, 0, 1, 2);
      tbl[3] = mk(0, 0, 0, 0, 1, 'h155, 1, 0, 0,   0,     0, 0, 0, 0, 3);
      tbl[4] = mk(1, 1, 0, 0, 0, 0,     0, 0, 0,   0,     0, 0, 1, 1, 3);
      tbl[5] = mk(0, 0, 0, 0, 0, 0,     0, 0, 1,   'h1A5, 1, 0, 1, 1, 3);
      tbl[6] = mk(0, 0, 0, 0, 0, 0,     0, 1, 1,   'h0F3, 1, 0, 1, 1, 3);
      tbl[7] = mk(0, 0, 0, 0, 0, 0,     0, 2, 1,   'h155, 1, 0, 1, 1, 3);
      tbl[8] = mk(0, 0, 0, 0, 0, 0,     0, 2, 0,   'h155, 0, 0, 1, 1, 3);
      tbl[9] = mk(0, 0, 1, 0, 0, 0,     0, 2, 0,   'h155, 0, 0, 1, 0, 3);

      @(negedge Clk);
      do_reset("reset");

      // Start on bank 2: no valid word until the first fetch.
      clear_inputs(); ProgSel = 2; Start = 1;
      cycle("start2");
      chk("start2 ActiveBank", int'(ActiveBank), 2);
      chk("start2 Busy", int'(Busy), 1);
      clear_inputs();
      cycle("start2 idle");
      chk("start2 InstValid", int'(InstValid), 0);
      Halt = 1;
      cycle("start2 halt");

      // Table: load bank 1 with three words and fetch them back.
      do_reset("reset2");
      foreach (tbl[i]) begin
         ProgSel = tbl[i].prog; Start = tbl[i].start; Halt = tbl[i].halt;
         LoadStart = tbl[i].lstart; LoadValid = tbl[i].lvalid; LoadData = tbl[i].ldata;
         LoadDone = tbl[i].ldone; InstAddress = tbl[i].addr; FetchReq = tbl[i].freq;
         Stall = tbl[i].stall;
         @(posedge Clk);
         model_step();
         @(negedge Clk);
         chk($sformatf("tbl%0d InstOut", i),    int'(InstOut),    tbl[i].e_out);
         chk($sformatf("tbl%0d InstValid", i),  int'(InstValid),  tbl[i].e_valid);
         chk($sformatf("tbl%0d AddrErr", i),    int'(AddrErr),    tbl[i].e_err);
         chk($sformatf("tbl%0d ActiveBank", i), int'(ActiveBank), tbl[i].e_bank);
         chk($sformatf("tbl%0d Busy", i),       int'(Busy),       tbl[i].e_busy);
         chk($sformatf("tbl%0d LoadCount", i),  int'(LoadCount),  tbl[i].e_cnt);
      end

      // Overflow: ten words into an eight-word bank.
      clear_inputs(); ProgSel = 0; LoadStart = 1;
      cycle("ovf start");
      for (int k = 0; k < 10; k++) begin
         clear_inputs(); LoadValid = 1; LoadData = DW'(32'h100 + 32'(k));
         cycle($sformatf("ovf w%0d", k));
      end
      chk("ovf LoadCount", int'(LoadCount), 8);
      clear_inputs(); LoadDone = 1;
      cycle("ovf done");
      clear_inputs(); ProgSel = 0; Start = 1;
      cycle("ovf run");
      fetch(9, "ovf a9");
      chk("ovf a9 InstOut", int'(InstOut), 0);
      chk("ovf a9 AddrErr", int'(AddrErr), 1);
      fetch(7, "ovf a7");
      chk("ovf a7 InstOut", int'(InstOut), 'h107);
      chk("ovf a7 AddrErr", int'(AddrErr), 0);
      clear_inputs(); Halt = 1;
      cycle("ovf halt");

      // Stall holds the word while FetchReq and address keep changing.
      clear_inputs(); ProgSel = 1; Start = 1;
      cycle("stall run");
      fetch(1, "stall a1");
      for (int k = 0; k < 3; k++) begin
         clear_inputs(); Stall = 1; FetchReq = 1; InstAddress = IW'((k == 1) ? 9 : k * 2);
         cycle($sformatf("stall c%0d", k));
         chk($sformatf("stall c%0d InstOut", k), int'(InstOut), 'h0F3);
         chk($sformatf("stall c%0d InstValid", k), int'(InstValid), 1);
      end
      clear_inputs();
      cycle("stall drop");
      chk("stall drop InstValid", int'(InstValid), 0);

      // In RUN, LoadStart/Start are ignored; from IDLE both together enter LOAD.
      clear_inputs(); ProgSel = 3; LoadStart = 1; Start = 1;
      cycle("run ignore");
      chk("run ignore ActiveBank", int'(ActiveBank), 1);
      chk("run ignore LoadCount", int'(LoadCount), 8);
      clear_inputs(); Halt = 1;
      cycle("ign halt");
      clear_inputs(); ProgSel = 3; LoadStart = 1; Start = 1;
      cycle("both");
      chk("both Busy", int'(Busy), 1);
      chk("both LoadCount", int'(LoadCount), 0);
      chk("both ActiveBank", int'(ActiveBank), 1);

      // Reset mid-load after two words; image must survive.
      clear_inputs(); LoadValid = 1; LoadData = 'h0AA;
      cycle("mid w0");
      LoadData = 'h055;
      cycle("mid w1");
      clear_inputs();
      do_reset("mid reset");
      chk("mid reset LoadCount", int'(LoadCount), 0);
      chk("mid reset Busy", int'(Busy), 0);
      clear_inputs(); ProgSel = 3; Start = 1;
      cycle("mid run");
      fetch(0, "mid a0");
      chk("mid a0 InstOut", int'(InstOut), 'h0AA);
      fetch(1, "mid a1");
      chk("mid a1 InstOut", int'(InstOut), 'h055);
      clear_inputs(); Halt = 1;
      cycle("mid halt");

      // Random traffic against the model.
      for (int n = 0; n < 800; n++) begin
         if ($urandom_range(0, 199) == 0) begin
            clear_inputs();
            do_reset("rnd reset");
         end
         ProgSel     = BW'($urandom_range(0, 3));
         Start       = ($urandom_range(0, 9) == 0);
         Halt        = ($urandom_range(0, 24) == 0);
         LoadStart   = ($urandom_range(0, 29) == 0);
         LoadValid   = ($urandom_range(0, 1) == 1);
         LoadData    = DW'($urandom);
         LoadDone    = ($urandom_range(0, 11) == 0);
         InstAddress = IW'($urandom_range(0, 15));
         FetchReq    = ($urandom_range(0, 9) < 7);
         Stall       = ($urandom_range(0, 3) == 0);
         cycle($sformatf("rnd%0d", n));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
